// File: rtl/seq_detect_fsm.sv
// -----------------------------------------------------------------------------
// seq_detect_fsm
//
// Two-button serial bit entry with pattern detection. btnU enters a 1 and btnD
// enters a 0. Each raw button is synchronised, debounced and edge-detected. The
// last SEQ_LEN accepted bits are compared against PATTERN. Matches may overlap
// (OVERLAP=1), or the history is flushed after every match (OVERLAP=0).
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous reset, active-low
//   btnU   in   raw push-button that enters a 1 (asynchronous, bouncy)
//   btnD   in   raw push-button that enters a 0 (asynchronous, bouncy)
//   clr    in   synchronous clear of history, fill, match count and hold
//   match  out  one-cycle pulse per detected match
//   led    out  [7:0] history, [11:8] fill, [14:12] match count, [15] hold
// -----------------------------------------------------------------------------
module seq_detect_fsm #(
  parameter int unsigned        SEQ_LEN  = 6,
  parameter logic [SEQ_LEN-1:0] PATTERN  = 6'b100110,
  parameter int unsigned        DB_CYC   = 1000,
  parameter bit                 OVERLAP  = 1'b1,
  parameter int unsigned        HOLD_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        clr,
  output logic        match,
  output logic [15:0] led
);

  localparam int unsigned        CNT_W     = $clog2(DB_CYC);
  localparam logic [CNT_W-1:0]   DB_LAST   = CNT_W'(DB_CYC - 1);
  localparam int unsigned        HOLD_W    = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [3:0]         FILL_FULL = 4'(SEQ_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_ARMED
  } state_e;

  // ---------------------------------------------------------------------------
  // Input path. Index 0 is btnU, index 1 is btnD.
  // ---------------------------------------------------------------------------
  logic [1:0]       sync1_q;
  logic [1:0]       sync2_q;
  logic [1:0]       db_q;       // debounced level
  logic [1:0]       armed_q;    // button seen released since reset
  logic [1:0]       rise_q;     // one-cycle strobe on debounced rising edge
  logic [CNT_W-1:0] db_cnt_q  [2];
  logic [CNT_W-1:0] arm_cnt_q [2];

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of its sources regardless of the
  // order statements appear in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      armed_q <= '0;
      rise_q  <= '0;
      // NOTE: these small counter arrays are control state and are reset
      // element by element; a real storage memory would be left unreset.
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i]  <= '0;
        arm_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= {btnD, btnU};
      sync2_q <= sync1_q;
      rise_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        // The counter only runs while the synced level disagrees with the
        // debounced level; any bounce back to agreement restarts the window.
        if (sync2_q[i] != db_q[i]) begin
          if (db_cnt_q[i] == DB_LAST) begin
            db_q[i]     <= sync2_q[i];
            db_cnt_q[i] <= '0;
            rise_q[i]   <= sync2_q[i] & armed_q[i];
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end

        // A button held through reset must not produce an entry once its
        // debounced level catches up, so rising edges are ignored until the
        // synced input has been low for a full debounce window.
        if (!armed_q[i]) begin
          if (sync2_q[i]) begin
            arm_cnt_q[i] <= '0;
          end else if (arm_cnt_q[i] == DB_LAST) begin
            armed_q[i] <= 1'b1;
          end else begin
            arm_cnt_q[i] <= arm_cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Simultaneous rises on both buttons cancel; a rise while the other button
  // is merely held is accepted.
  logic ev;
  logic ev_bit;

  assign ev     = rise_q[0] ^ rise_q[1];
  assign ev_bit = rise_q[0];

  // ---------------------------------------------------------------------------
  // History / fill / match FSM
  // ---------------------------------------------------------------------------
  state_e             state_q;
  logic [SEQ_LEN-1:0] hist_q;
  logic [3:0]         fill_q;
  logic               match_q;
  logic [2:0]         match_cnt_q;
  logic               hold_q;
  logic [HOLD_W-1:0]  hold_cnt_q;

  logic [SEQ_LEN-1:0] hist_base;
  logic [3:0]         fill_base;
  state_e             state_base;
  logic [SEQ_LEN-1:0] hist_d;
  logic [3:0]         fill_d;
  state_e             state_d;
  logic               match_d;

  // NOTE: every signal assigned here gets a value on every path (defaults
  // first), so the block stays purely combinational with no latches.
  always_comb begin
    hist_base  = hist_q;
    fill_base  = fill_q;
    state_base = state_q;
    // Without overlap the matched history is shown for the match cycle and
    // flushed at its end, before any further bit is shifted in.
    if (!OVERLAP && match_q) begin
      hist_base  = '0;
      fill_base  = '0;
      state_base = S_IDLE;
    end

    hist_d = hist_base;
    fill_d = fill_base;
    if (ev) begin
      hist_d = {hist_base[SEQ_LEN-2:0], ev_bit};
      fill_d = (state_base == S_ARMED) ? fill_base : fill_base + 4'd1;
    end

    if (fill_d == 4'd0) begin
      state_d = S_IDLE;
    end else if (fill_d == FILL_FULL) begin
      state_d = S_ARMED;
    end else begin
      state_d = S_FILL;
    end

    // Only a fresh bit can complete a match, so a retained history never
    // re-fires on its own.
    match_d = ev && (state_d == S_ARMED) && (hist_d == PATTERN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      hist_q      <= '0;
      fill_q      <= '0;
      match_q     <= 1'b0;
      match_cnt_q <= '0;
      hold_q      <= 1'b0;
      hold_cnt_q  <= '0;
    end else if (clr) begin
      // Clear wins over an event in the same cycle; that event is dropped.
      state_q     <= S_IDLE;
      hist_q      <= '0;
      fill_q      <= '0;
      match_q     <= 1'b0;
      match_cnt_q <= '0;
      hold_q      <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;

      if (match_d && (match_cnt_q != 3'd7)) begin
        match_cnt_q <= match_cnt_q + 3'd1;
      end

      // The hold bit is lit for HOLD_CYC cycles; a new match reloads it.
      if (match_d) begin
        hold_q     <= 1'b1;
        hold_cnt_q <= HOLD_LAST;
      end else if (hold_q) begin
        if (hold_cnt_q == '0) begin
          hold_q <= 1'b0;
        end else begin
          hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs come straight from flops.
  // ---------------------------------------------------------------------------
  logic [7:0] hist_led;

  assign hist_led = 8'(hist_q);
  assign match    = match_q;
  assign led      = {hold_q, match_cnt_q, fill_q, hist_led};

endmodule

// File: tb/tb_seq_detect_fsm.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_fsm
//
// Three detector instances share the same button, clear and reset inputs:
//   dut 0 : SEQ_LEN=6, PATTERN=100110, overlapping
//   dut 1 : SEQ_LEN=6, PATTERN=100110, non-overlapping
//   dut 2 : SEQ_LEN=2, PATTERN=11,     overlapping
// Debounce and hold windows are shortened to keep the run short. A bench model
// of each instance pushes the expected led value of every match onto a queue
// when the bit is entered; a monitor pops it when the instance pulses match.
// -----------------------------------------------------------------------------
module tb_seq_detect_fsm;

  localparam int DB    = 20;
  localparam int HOLD  = 200;
  localparam int PRESS = 60;
  localparam int REL   = 40;

  logic        clk;
  logic        rst;
  logic        btnU;
  logic        btnD;
  logic        clr;
  logic        match_a, match_b, match_c;
  logic [15:0] led_a, led_b, led_c;

  seq_detect_fsm #(
    .SEQ_LEN(6), .PATTERN(6'b100110), .DB_CYC(DB), .OVERLAP(1'b1), .HOLD_CYC(HOLD)
  ) dut_a (
    .clk(clk), .rst(rst), .btnU(btnU), .btnD(btnD), .clr(clr),
    .match(match_a), .led(led_a)
  );

  seq_detect_fsm #(
    .SEQ_LEN(6), .PATTERN(6'b100110), .DB_CYC(DB), .OVERLAP(1'b0), .HOLD_CYC(HOLD)
  ) dut_b (
    .clk(clk), .rst(rst), .btnU(btnU), .btnD(btnD), .clr(clr),
    .match(match_b), .led(led_b)
  );

  seq_detect_fsm #(
    .SEQ_LEN(2), .PATTERN(2'b11), .DB_CYC(DB), .OVERLAP(1'b1), .HOLD_CYC(HOLD)
  ) dut_c (
    .clk(clk), .rst(rst), .btnU(btnU), .btnD(btnD), .clr(clr),
    .match(match_c), .led(led_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  int cfg_len [3] = '{6, 6, 2};
  int cfg_pat [3] = '{'h26, 'h26, 'h3};
  bit cfg_ovl [3] = '{1'b1, 1'b0, 1'b1};

  int m_hist [3];
  int m_fill [3];
  int m_cnt  [3];

  logic [15:0] q_a [$];
  logic [15:0] q_b [$];
  logic [15:0] q_c [$];

  int unsigned match_cyc_a = 0;

  task automatic sb_push(input int idx, input logic [15:0] v);
    case (idx)
      0:       q_a.push_back(v);
      1:       q_b.push_back(v);
      default: q_c.push_back(v);
    endcase
  endtask

  function automatic int sb_size(input int idx);
    case (idx)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic sb_pop(input int idx, input logic [15:0] obs);
    int          sz;
    logic [15:0] exp;
    sz = sb_size(idx);
    checks++;
    assert (sz != 0) else begin
      errors++;
      $error("FAIL unexpected_match_dut%0d: observed match with led=0x%0h, expected no match", idx, obs);
    end
    if (sz != 0) begin
      case (idx)
        0:       exp = q_a.pop_front();
        1:       exp = q_b.pop_front();
        default: exp = q_c.pop_front();
      endcase
      check($sformatf("match_led_dut%0d", idx), 32'(obs), 32'(exp));
    end
  endtask

  task automatic model_event(input bit b);
    for (int i = 0; i < 3; i++) begin
      m_hist[i] = ((m_hist[i] << 1) | int'(b)) & ((1 << cfg_len[i]) - 1);
      if (m_fill[i] < cfg_len[i]) m_fill[i]++;
      if (m_fill[i] == cfg_len[i] && m_hist[i] == cfg_pat[i]) begin
        if (m_cnt[i] < 7) m_cnt[i]++;
        sb_push(i, {1'b1, 3'(m_cnt[i]), 4'(m_fill[i]), 8'(m_hist[i])});
        if (!cfg_ovl[i]) begin
          m_hist[i] = 0;
          m_fill[i] = 0;
        end
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_hist[i] = 0;
      m_fill[i] = 0;
      m_cnt[i]  = 0;
    end
  endtask

  // led[14:0] expected from the model; the hold bit is checked separately.
  function automatic logic [31:0] model_led(input int idx);
    return 32'({1'b0, 3'(m_cnt[idx]), 4'(m_fill[idx]), 8'(m_hist[idx])});
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && match_a === 1'b1) begin
      match_cyc_a = cyc;
      sb_pop(0, led_a);
    end
    if (rst === 1'b1 && match_b === 1'b1) sb_pop(1, led_b);
    if (rst === 1'b1 && match_c === 1'b1) sb_pop(2, led_c);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic press(input logic u, input logic d);
    @(posedge clk); #1;
    btnU = u;
    btnD = d;
    repeat (PRESS) @(posedge clk);
    #1;
    btnU = 1'b0;
    btnD = 1'b0;
    repeat (REL) @(posedge clk);
  endtask

  task automatic enter(input bit b);
    model_event(b);
    if (b) press(1'b1, 1'b0);
    else   press(1'b0, 1'b1);
  endtask

  // Enters bits[n-1] first (oldest) down to bits[0].
  task automatic enter_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) enter(bits[i]);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
    repeat (DB + 10) @(posedge clk);
  endtask

  task automatic check_leds(input string tag);
    check({tag, "_a"}, 32'({1'b0, led_a[14:0]}), model_led(0));
    check({tag, "_b"}, 32'({1'b0, led_b[14:0]}), model_led(1));
    check({tag, "_c"}, 32'({1'b0, led_c[14:0]}), model_led(2));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int k;
    btnU = 1'b0;
    btnD = 1'b0;
    clr  = 1'b0;
    rst  = 1'b0;
    model_clear();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_led_a", 32'(led_a), 32'h0);
    check("rst_led_b", 32'(led_b), 32'h0);
    check("rst_led_c", 32'(led_c), 32'h0);
    check("rst_match", 32'({match_a, match_b, match_c}), 32'h0);
    rst = 1'b1;
    repeat (DB + 10) @(posedge clk);

    // First full pattern, then measure how long the hold bit stays lit
    enter_bits(16'b100110, 6);
    k = 0;
    while (led_a[15] !== 1'b0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("hold_cycles", 32'(cyc - match_cyc_a), 32'(HOLD));
    check_leds("seq1");

    // Continue to 1001100110: overlap matches again, non-overlap does not
    enter_bits(16'b0110, 4);
    check_leds("seq2");

    // Short glitch and bounce on btnU: nothing may be entered
    @(posedge clk); #1;
    btnU = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    btnU = 1'b0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      btnU = ~btnU;
      repeat (1 + (i % 3)) @(posedge clk);
    end
    #1;
    btnU = 1'b0;
    repeat (3 * DB) @(posedge clk);
    check_leds("glitch");

    // Both buttons rising together are dropped; btnU alone is then accepted
    press(1'b1, 1'b1);
    check_leds("both_rise");
    enter(1'b1);
    check_leds("u_after_both");

    // btnU rising while btnD is held is a normal entry
    @(posedge clk); #1;
    btnD = 1'b1;
    model_event(1'b0);
    repeat (PRESS) @(posedge clk);
    #1;
    btnU = 1'b1;
    model_event(1'b1);
    repeat (PRESS) @(posedge clk);
    #1;
    btnU = 1'b0;
    btnD = 1'b0;
    repeat (REL) @(posedge clk);
    check_leds("u_while_d_held");

    // clr held across a whole press: everything cleared, the event is lost
    @(posedge clk); #1;
    clr = 1'b1;
    press(1'b1, 1'b0);
    #1;
    clr = 1'b0;
    model_clear();
    check("clr_held_a", 32'(led_a), 32'h0);
    check("clr_held_c", 32'(led_c), 32'h0);

    // Reset in the middle of a press, with the button held through release
    enter_bits(16'b100, 3);
    @(posedge clk); #1;
    btnU = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_led_a", 32'(led_a), 32'h0);
    check("midrst_led_b", 32'(led_b), 32'h0);
    check("midrst_led_c", 32'(led_c), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
    repeat (PRESS) @(posedge clk);
    #1;
    btnU = 1'b0;
    repeat (REL + 2 * DB + 20) @(posedge clk);
    check_leds("held_through_rst");
    // Five bits only: a wrongly entered held 1 would complete the pattern
    enter_bits(16'b00110, 5);
    check_leds("after_rst_5bits");
    enter_bits(16'b100110, 6);
    check_leds("after_rst_full");

    // Saturating count on the 2-bit instance: ten 1s give nine matches
    do_reset();
    for (int i = 0; i < 10; i++) enter(1'b1);
    check("sat_led_c", 32'(led_c), model_led(2) | 32'h8000);
    check_leds("sat");

    // Single-cycle clr pulse clears on the next edge
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_clear();
    check("clr_pulse_led_c", 32'(led_c), 32'h0);
    check("clr_pulse_led_a", 32'(led_a), 32'h0);
    check("clr_pulse_match", 32'({match_a, match_b, match_c}), 32'h0);

    // Every expected match must have been seen
    repeat (20) @(posedge clk);
    check("sb_left_a", 32'(q_a.size()), 32'h0);
    check("sb_left_b", 32'(q_b.size()), 32'h0);
    check("sb_left_c", 32'(q_c.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
